// File: rtl/axil_master_port.sv
// axil_master_port: single-outstanding AXI4-Lite master behind a valid/ready command/response port.
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata/wstrb   command in (accepted only in IDLE)
//   rsp_valid/ready/rdata/error   response out (rdata is 0 for writes, error = resp != OKAY)
//   m_axil_aw*/w*/b*              AXI4-Lite write channels
//   m_axil_ar*/r*                 AXI4-Lite read channels
module axil_master_port #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
    state_t state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done, w_done;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end
    // The direction is carried by the state itself, so only the payload is latched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
            // Per-channel completion flags let AW and W finish in any order; they self-clear outside the write phase.
            aw_done <= (state == WR_ADDR_DATA) && (aw_done || m_axil_awready);
            w_done  <= (state == WR_ADDR_DATA) && (w_done || m_axil_wready);
            if (state == WR_RESP && m_axil_bvalid) begin
                rsp_rdata <= '0;
                rsp_error <= (m_axil_bresp != 2'b00);
            end
            if (state == RD_DATA && m_axil_rvalid) begin
                rsp_rdata <= m_axil_rdata;
                rsp_error <= (m_axil_rresp != 2'b00);
            end
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (cmd_valid) next_state = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if ((aw_done || m_axil_awready) && (w_done || m_axil_wready)) next_state = WR_RESP;
            WR_RESP:      if (m_axil_bvalid) next_state = RESP;
            RD_ADDR:      if (m_axil_arready) next_state = RD_DATA;
            RD_DATA:      if (m_axil_rvalid) next_state = RESP;
            RESP:         if (rsp_ready) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end
    always_comb begin
        cmd_ready      = (state == IDLE);
        m_axil_awvalid = (state == WR_ADDR_DATA) && !aw_done;
        m_axil_wvalid  = (state == WR_ADDR_DATA) && !w_done;
        m_axil_bready  = (state == WR_RESP);
        m_axil_arvalid = (state == RD_ADDR);
        m_axil_rready  = (state == RD_DATA);
        rsp_valid      = (state == RESP);
        m_axil_awaddr  = addr_q;
        m_axil_araddr  = addr_q;
        m_axil_wdata   = wdata_q;
        m_axil_wstrb   = wstrb_q;
        m_axil_awprot  = PROT;
        m_axil_arprot  = PROT;
    end
endmodule

// File: tb/tb_axil_master_port.sv
// tb_axil_master_port: randomized self-checking bench with an in-bench AXI-Lite slave and transaction-level expectations.
module tb_axil_master_port;
    logic        aclk, aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    axil_master_port dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave behaviour knobs, set by the main sequence before each command.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  resp_code = 2'b00;
    logic [31:0] rd_value = '0;
    // What the slave actually saw on each address/data handshake.
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    // Slave: everything happens on the falling edge so the DUT samples stable inputs at the rising edge.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic aw_got, w_got, ar_got, b_fire, r_fire, aw_pv, w_pv, ar_pv;
        logic [31:0] aw_pa, ar_pa;
        logic [35:0] w_pd;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        {aw_got, w_got, ar_got, b_fire, r_fire, aw_pv, w_pv, ar_pv} = '0;
        {m_axil_awready, m_axil_wready, m_axil_arready, m_axil_bvalid, m_axil_rvalid} = '0;
        m_axil_bresp = 2'b00; m_axil_rresp = 2'b00; m_axil_rdata = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
                {aw_got, w_got, ar_got, b_fire, r_fire, aw_pv, w_pv, ar_pv} = '0;
                {m_axil_awready, m_axil_wready, m_axil_arready, m_axil_bvalid, m_axil_rvalid} = '0;
            end else begin
                if (m_axil_awready) begin
                    m_axil_awready = 1'b0; aw_got = 1'b1;
                    check("awvalid_drop", m_axil_awvalid, 1'b0);
                end else if (aw_pv) check("aw_hold", {m_axil_awvalid, m_axil_awaddr}, {1'b1, aw_pa});
                if (m_axil_wready) begin
                    m_axil_wready = 1'b0; w_got = 1'b1;
                    check("wvalid_drop", m_axil_wvalid, 1'b0);
                end else if (w_pv) check("w_hold", {m_axil_wvalid, m_axil_wdata, m_axil_wstrb}, {1'b1, w_pd});
                if (m_axil_arready) begin
                    m_axil_arready = 1'b0; ar_got = 1'b1;
                    check("arvalid_drop", m_axil_arvalid, 1'b0);
                end else if (ar_pv) check("ar_hold", {m_axil_arvalid, m_axil_araddr}, {1'b1, ar_pa});
                if (b_fire) begin m_axil_bvalid = 1'b0; b_fire = 1'b0; aw_got = 1'b0; w_got = 1'b0; end
                if (r_fire) begin m_axil_rvalid = 1'b0; r_fire = 1'b0; ar_got = 1'b0; end
                if (m_axil_awvalid) begin
                    if (aw_cnt >= aw_delay) begin m_axil_awready = 1'b1; aw_cnt = 0; cap_awaddr = m_axil_awaddr; end
                    else aw_cnt++;
                end
                if (m_axil_wvalid) begin
                    if (w_cnt >= w_delay) begin
                        m_axil_wready = 1'b1; w_cnt = 0; cap_wdata = m_axil_wdata; cap_wstrb = m_axil_wstrb;
                    end else w_cnt++;
                end
                if (m_axil_arvalid) begin
                    if (ar_cnt >= ar_delay) begin m_axil_arready = 1'b1; ar_cnt = 0; cap_araddr = m_axil_araddr; end
                    else ar_cnt++;
                end
                if (!m_axil_bvalid && aw_got && w_got) begin
                    if (b_cnt >= b_delay) begin m_axil_bvalid = 1'b1; m_axil_bresp = resp_code; b_cnt = 0; end
                    else b_cnt++;
                end
                if (m_axil_bvalid && m_axil_bready) b_fire = 1'b1;
                if (!m_axil_rvalid && ar_got) begin
                    if (r_cnt >= r_delay) begin
                        m_axil_rvalid = 1'b1; m_axil_rresp = resp_code; m_axil_rdata = rd_value; r_cnt = 0;
                    end else r_cnt++;
                end
                if (m_axil_rvalid && m_axil_rready) r_fire = 1'b1;
                if (m_axil_bready) check("bready_early", aw_got && w_got, 1'b1);
                if (m_axil_rready) check("rready_early", ar_got, 1'b1);
                aw_pv = m_axil_awvalid && !m_axil_awready; aw_pa = m_axil_awaddr;
                w_pv  = m_axil_wvalid && !m_axil_wready;   w_pd  = {m_axil_wdata, m_axil_wstrb};
                ar_pv = m_axil_arvalid && !m_axil_arready; ar_pa = m_axil_araddr;
            end
        end
    end

    // One complete command/response exchange; expectations come from the transaction rules only:
    // latency is 3 cycles plus slave stalls, reads return the slave data, writes return 0, error = resp != OKAY.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] rc, input logic [31:0] rv, input int awd, input int wd, input int bd,
                          input int ard, input int rdl, input int hold, input logic busy_cmd);
        int lat, exp_lat;
        logic [31:0] exp_rdata;
        @(negedge aclk);
        aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rdl;
        resp_code = rc; rd_value = rv;
        cap_awaddr = 'x; cap_wdata = 'x; cap_wstrb = 'x; cap_araddr = 'x;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge aclk);
        cmd_valid = 1'b0;
        cmd_write = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
        check("cmd_ready_busy", cmd_ready, 1'b0);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge aclk);
            lat++;
        end
        exp_lat   = wr ? 3 + (awd > wd ? awd : wd) + bd : 3 + ard + rdl;
        exp_rdata = wr ? 32'h0 : rv;
        check("rsp_valid", rsp_valid, 1'b1);
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_error", rsp_error, rc != 2'b00);
        if (busy_cmd) cmd_valid = 1'b1;
        repeat (hold) begin
            @(negedge aclk);
            check("rsp_hold", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, rc != 2'b00, exp_rdata});
            check("cmd_ready_resp", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("rsp_drop", rsp_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
        if (wr) check("aw_w_payload", {cap_awaddr, cap_wdata, cap_wstrb}, {a, d, s});
        else    check("ar_payload", cap_araddr, a);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready,
                               rsp_valid, rsp_error}, 7'b0);
        check("reset_data", {rsp_rdata, m_axil_awaddr, m_axil_araddr, m_axil_wdata, m_axil_wstrb}, 132'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("prot", {m_axil_awprot, m_axil_arprot}, 6'b0);
        #2 aresetn = 1'b1;
        // Always-ready slave write: 3-cycle latency, rdata 0, no error.
        do_txn(1'b1, 32'h0, 32'h1, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0, 1'b0);
        // AW stalled 3 cycles while W completes at once; B must wait for both.
        do_txn(1'b1, 32'h40, 32'hCAFE_F00D, 4'h5, 2'b00, 32'h0, 3, 0, 0, 0, 0, 1, 1'b0);
        // W stalled instead of AW.
        do_txn(1'b1, 32'h44, 32'h1234_5678, 4'hA, 2'b00, 32'h0, 0, 2, 1, 0, 0, 0, 1'b0);
        // Read with 4 cycles of rvalid low.
        do_txn(1'b0, 32'h0, 32'h0, 4'h0, 2'b00, 32'h1, 0, 0, 0, 0, 4, 0, 1'b0);
        // SLVERR read, then an OKAY read, then a DECERR write.
        do_txn(1'b0, 32'h8, 32'h0, 4'h0, 2'b10, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 1'b0);
        do_txn(1'b0, 32'hC, 32'h0, 4'h0, 2'b00, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 1'b0);
        do_txn(1'b1, 32'hFFFF_FFFC, 32'h7, 4'h1, 2'b11, 32'h0, 0, 0, 2, 0, 0, 0, 1'b0);
        // Response held 5 cycles with a new command pending.
        do_txn(1'b0, 32'h100, 32'h0, 4'h0, 2'b00, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 5, 1'b1);
        // Reset during a stalled write: outputs must drop without a clock.
        @(negedge aclk);
        aw_delay = 1000; w_delay = 0;
        cmd_write = 1'b1; cmd_addr = 32'h200; cmd_wdata = 32'h9; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge aclk);
        check("rst_pre_awvalid", m_axil_awvalid, 1'b1);
        #2 aresetn = 1'b0;
        #1;
        check("rst_async_valids", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, rsp_valid}, 4'b0);
        check("rst_async_cmd_ready", cmd_ready, 1'b1);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        do_txn(1'b0, 32'h204, 32'h0, 4'h0, 2'b00, 32'h1357_9BDF, 0, 0, 0, 0, 0, 0, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] rc;
            rc = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), rc, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_master_port.md
Name: axil_master_port

Overview:
- Single-outstanding AXI4-Lite master.
- Converts a simple valid/ready command/response interface into AXI4-Lite read and write transactions.
- Lets internal engines (boot sequencer, DMA setup, debug bridge) program AXI-Lite slaves on the system interconnect, such as the configuration memory.
- Exactly one transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 32, AXI address and cmd_addr width
DATA_WIDTH, 32, AXI data width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
PROT, 3'b000, constant value driven on m_axil_awprot and m_axil_arprot

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_error  out  1  1 if BRESP/RRESP != OKAY
m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  AW channel
m_axil_awready  in  1
m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH/STRB_WIDTH/1  W channel
m_axil_wready  in  1
m_axil_bresp  in  2;  m_axil_bvalid  in  1;  m_axil_bready  out  1
m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  AR channel
m_axil_arready  in  1
m_axil_rdata  in  DATA_WIDTH;  m_axil_rresp  in  2;  m_axil_rvalid  in  1;  m_axil_rready  out  1

Behaviour:

States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.

Reset:
- Asynchronous assertion forces IDLE immediately.
- All *valid, bready, rready, rsp_valid and rsp_error go to 0; rsp_rdata, awaddr, araddr, wdata and wstrb go to 0.
- Reset mid-transaction abandons it with no response. Deassertion is synchronised by the integrator.

Command acceptance:
- cmd_ready = (state == IDLE), combinational from state only.
- On the accept edge, latch address, data, strobe and direction.

Write path:
- IDLE -> WR_ADDR_DATA; awvalid and wvalid both rise the cycle after acceptance.
- Each valid drops on the clock edge after its own handshake, independently. AW and W may complete in either order or in the same cycle.
- awaddr, wdata and wstrb stay stable while the corresponding valid is high.
- When both handshakes are done -> WR_RESP with bready = 1.
- On bvalid && bready: capture error = (bresp != 0), rsp_rdata = 0, bready -> 0, go to RESP.

Read path:
- IDLE -> RD_ADDR; arvalid high until the arready handshake, then RD_DATA with rready = 1.
- On rvalid && rready: capture rdata and error = (rresp != 0), rready -> 0, go to RESP.

RESP:
- rsp_valid = 1 with rsp_rdata and rsp_error held stable until rsp_ready, then IDLE.
- rsp_valid = 1 and rsp_ready = 1 in the same cycle returns to IDLE on that edge.
- A new command can be accepted the cycle after that.

Protocol rules:
- No valid is ever deasserted before its handshake.
- bready is only high in WR_RESP; rready is only high in RD_DATA.
- B/R beats arriving in other states are not consumed.

Latency (slave always ready and responding next cycle):
- Command accepted at cycle N -> AW/W or AR handshake at N+1 -> B/R handshake at N+2 -> rsp_valid at N+3.

Widths:
- Addresses pass through unmodified. No alignment check; the slave decodes.

Test Plan:
1. Always-ready slave, write addr 0x0, wdata 0x1, wstrb 0xF -> AW and W handshake together at N+1; bready at N+2; rsp_valid at N+3 with rsp_error = 0, rsp_rdata = 0.
2. Write with awready held low 3 cycles while wready = 1 -> wvalid drops after 1 cycle; awvalid stays high with addr stable until awready; bready only rises after both complete.
3. Read addr 0x0, slave returns rdata 0x1 after 4 cycles of rvalid low -> rready held high throughout; rsp_rdata = 0x1, rsp_error = 0.
4. Read with rresp = 2'b10 (SLVERR) -> rsp_error = 1; next read with OKAY -> rsp_error = 0.
5. rsp_ready held low 5 cycles, then cmd_valid asserted -> cmd_ready stays 0 and rsp_* stay stable; cmd_ready returns the cycle after the rsp handshake.
6. aresetn pulled low while awvalid = 1 and awready = 0 -> awvalid, wvalid and rsp_valid drop immediately without a clock; after release, cmd_ready = 1 and a fresh read completes normally.
